// File: rtl/param_icache_if.sv
// param_icache_if: valid/ready request and response bundle used on both the CPU and memory sides
interface param_icache_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_last;
   modport master (output req_valid, req_addr, rsp_ready, input req_ready, rsp_valid, rsp_data, rsp_last);
   modport slave (input req_valid, req_addr, rsp_ready, output req_ready, rsp_valid, rsp_data, rsp_last);
endinterface

// File: rtl/param_icache.sv
// param_icache: set-associative read-only instruction cache with round-robin refill, flush sequencer and hit/miss counters
module param_icache #(
   parameter int SETS       = 8,
   parameter int WAYS       = 4,
   parameter int LINE_WORDS = 8,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   param_icache_if.slave    cpu,
   param_icache_if.master   mem,
   input  logic             inv_req,
   output logic             inv_done,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);
   localparam int OFF = $clog2(LINE_WORDS*4);
   localparam int IDX = $clog2(SETS);
   localparam int TAG = 32-OFF-IDX;
   localparam int WW  = WAYS > 1 ? $clog2(WAYS) : 1;
   localparam int LB  = LINE_WORDS*32;
   typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, RECV, FILL, RESP, FLUSH} state_t;
   state_t state, next;
   logic [31:0] addr;
   logic [LB-1:0] line;
   logic [WW-1:0] victim, hit_way, pick;
   logic hit;
   logic [IDX-1:0] fcnt;
   logic [IDX-1:0] idx;
   logic [TAG-1:0] tag;
   logic [OFF-1:0] off;
   logic [WAYS-1:0] valid [SETS];
   logic [WW-1:0] ptr [SETS];
   logic [TAG-1:0] tags [SETS][WAYS];
   logic [LB-1:0] lines [SETS][WAYS];
   assign idx = addr[OFF+IDX-1:OFF];
   assign tag = addr[31:OFF+IDX];
   assign off = addr[OFF-1:0];
   // Tag match across the ways of the latched set, and refill choice: lowest invalid way, else the set's pointer
   always_comb begin
      hit = 1'b0;
      hit_way = '0;
      pick = ptr[idx];
      for (int w = WAYS-1; w >= 0; w--) begin
         if (valid[idx][w] && tags[idx][w] == tag) begin
            hit = 1'b1;
            hit_way = WW'(w);
         end
         if (!valid[idx][w]) pick = WW'(w);
      end
   end
   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= next;
   end
   // Next-state and handshake outputs; data and addresses are forced to zero outside their phases
   always_comb begin
      next = state;
      cpu.req_ready = 1'b0;
      cpu.rsp_valid = 1'b0;
      cpu.rsp_data = '0;
      cpu.rsp_last = 1'b0;
      mem.req_valid = 1'b0;
      mem.req_addr = '0;
      mem.rsp_ready = 1'b0;
      inv_done = 1'b0;
      case (state)
         IDLE: begin
            cpu.req_ready = 1'b1;
            next = inv_req ? FLUSH : cpu.req_valid ? LOOKUP : IDLE;
         end
         LOOKUP: next = hit ? RESP : MISS_REQ;
         MISS_REQ: begin
            mem.req_valid = 1'b1;
            mem.req_addr = {addr[31:OFF], {OFF{1'b0}}};
            next = mem.req_ready ? RECV : MISS_REQ;
         end
         RECV: begin
            mem.rsp_ready = 1'b1;
            next = mem.rsp_valid && mem.rsp_last ? FILL : RECV;
         end
         FILL: next = RESP;
         RESP: begin
            cpu.rsp_valid = 1'b1;
            cpu.rsp_data = line[32*int'(off >> 2) +: 32];
            next = cpu.rsp_ready ? IDLE : RESP;
         end
         FLUSH: begin
            inv_done = fcnt == IDX'(SETS-1);
            next = inv_done ? IDLE : FLUSH;
         end
         default: next = IDLE;
      endcase
   end
   // Datapath: address latch, line staging, array writes, pointer rotation, flush sweep and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt <= '0;
         miss_cnt <= '0;
         fcnt <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            ptr[s] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               fcnt <= '0;
               if (cpu.req_valid) addr <= cpu.req_addr;
            end
            LOOKUP: begin
               if (hit) begin
                  hit_cnt <= hit_cnt + 1'b1;
                  line <= lines[idx][hit_way];
               end else begin
                  miss_cnt <= miss_cnt + 1'b1;
                  victim <= pick;
               end
            end
            RECV: if (mem.rsp_valid) line <= {mem.rsp_data, line[LB-1:32]};
            FILL: begin
               valid[idx][victim] <= 1'b1;
               tags[idx][victim] <= tag;
               lines[idx][victim] <= line;
               if (victim == ptr[idx]) ptr[idx] <= WAYS == 1 ? '0 : ptr[idx] + 1'b1;
            end
            FLUSH: begin
               valid[fcnt] <= '0;
               ptr[fcnt] <= '0;
               fcnt <= fcnt + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
